// File: rtl/time_display_if.sv
// Time display bus: game timer values and blank in, LED drive out.
// The master is the timer side, the slave is the display driver.
interface time_display_if;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output seconds, minutes, blank,
    input  an, seg, dp
  );

  modport slave (
    input  seconds, minutes, blank,
    output an, seg, dp
  );
endinterface

// File: rtl/time_display.sv
// Four-digit MM:SS multiplexed seven-segment driver.
// Frame-synchronous snapshot, sequential double-dabble, registered drive.
module time_display #(
  parameter int DIGIT_CYCLES = 50_000
) (
  input logic           clock,
  input logic           reset,
  time_display_if.slave bus
);
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } conv_t;

  logic [CW-1:0] cnt;
  logic [1:0]    d;
  logic          first;
  logic          wrap;
  logic          capture;
  logic [5:0]    snap_s;
  logic [5:0]    snap_m;
  conv_t         state;
  logic [2:0]    step;
  logic [13:0]   sh_s;
  logic [13:0]   sh_m;
  logic [13:0]   nx_s;
  logic [13:0]   nx_m;
  logic [7:0]    disp_s;
  logic [7:0]    disp_m;
  logic [3:0]    digit;
  logic [6:0]    glyph;

  assign wrap    = (cnt == CNT_MAX);
  assign capture = first | (wrap & (d == 2'd3));

  // {tens, ones, binary}: add-3 on BCD nibbles >= 5, then shift left
  function automatic logic [13:0] dabble(input logic [13:0] v);
    logic [13:0] t;
    t = v;
    if (t[9:6] >= 4'd5) t[9:6] = t[9:6] + 4'd3;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  assign nx_s = dabble(sh_s);
  assign nx_m = dabble(sh_m);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      d      <= '0;
      first  <= 1'b1;
      snap_s <= '0;
      snap_m <= '0;
      state  <= IDLE;
      step   <= '0;
      sh_s   <= '0;
      sh_m   <= '0;
      disp_s <= '0;
      disp_m <= '0;
    end else begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      first <= 1'b0;
      if (wrap) d <= d + 2'd1;
      if (capture) begin
        snap_s <= bus.seconds;
        snap_m <= bus.minutes;
      end
      unique case (state)
        IDLE: begin
          if (capture) state <= LOAD;
        end
        LOAD: begin
          sh_s  <= {8'd0, snap_s};
          sh_m  <= {8'd0, snap_m};
          step  <= 3'd0;
          state <= SHIFT;
        end
        SHIFT: begin
          sh_s <= nx_s;
          sh_m <= nx_m;
          step <= step + 3'd1;
          if (step == 3'd5) begin
            disp_s <= nx_s[13:6];
            disp_m <= nx_m[13:6];
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    unique case (d)
      2'd0:    digit = disp_s[3:0];
      2'd1:    digit = disp_s[7:4];
      2'd2:    digit = disp_m[3:0];
      default: digit = disp_m[7:4];
    endcase
  end

  always_comb begin
    unique case (digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7f;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.an  <= 4'hf;
      bus.seg <= 7'h7f;
      bus.dp  <= 1'b1;
    end else if (bus.blank || (d == 2'd3 && digit == 4'd0)) begin
      bus.an  <= 4'hf;
      bus.seg <= 7'h7f;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(4'b0001 << d);
      bus.seg <= glyph;
      bus.dp  <= (d != 2'd2);
    end
  end
endmodule

// File: tb/tb_time_display.sv
// Bench for time_display: vector table through a scoreboard queue,
// plus hand sequences for hold, blank and reset corner cases.
module tb_time_display;
  localparam int DC = 8;
  localparam int FRAME = 4 * DC;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  time_display_if bus();

  time_display #(.DIGIT_CYCLES(DC)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  typedef struct {
    int         sec;
    int         min;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
    logic [6:0] s3;
    bit         dark3;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   k;
  int   checks;
  int   passed;
  int   base;

  task automatic check(input string name, input logic [3:0] an_e,
                       input logic [6:0] seg_e, input logic dp_e);
    checks++;
    if (bus.an === an_e && bus.seg === seg_e && bus.dp === dp_e)
      passed++;
    else
      $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               name, bus.an, bus.seg, bus.dp, an_e, seg_e, dp_e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    k++;
  endtask

  task automatic tick_to(input int t);
    while (k < t) tick();
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg,
                      input logic dp, input string name);
    exp_t e;
    e.an = an;
    e.seg = seg;
    e.dp = dp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL sb_empty: got no expected entry, want one queued");
    end else begin
      e = sb.pop_front();
      check(e.name, e.an, e.seg, e.dp);
    end
  endtask

  task automatic push_vec(input int id, input vec_t v);
    push(4'b1110, v.s0, 1'b1, $sformatf("v%0d_d0", id));
    push(4'b1101, v.s1, 1'b1, $sformatf("v%0d_d1", id));
    push(4'b1011, v.s2, 1'b0, $sformatf("v%0d_d2", id));
    if (v.dark3)
      push(4'b1111, 7'h7f, 1'b1, $sformatf("v%0d_d3", id));
    else
      push(4'b0111, v.s3, 1'b1, $sformatf("v%0d_d3", id));
  endtask

  // Land on a frame boundary one full frame after the next capture
  task automatic to_frame();
    do tick(); while (k % FRAME != 0);
    repeat (FRAME) tick();
  endtask

  task automatic observe_frame();
    for (int i = 0; i < 4; i++) begin
      repeat (DC / 2) tick();
      pop_check();
      repeat (DC / 2) tick();
    end
  endtask

  initial begin
    vecs[0] = '{37, 12, 7'h78, 7'h30, 7'h24, 7'h79, 1'b0};
    vecs[1] = '{9, 5, 7'h10, 7'h40, 7'h12, 7'h7f, 1'b1};
    vecs[2] = '{63, 63, 7'h30, 7'h02, 7'h30, 7'h02, 1'b0};
    vecs[3] = '{0, 0, 7'h40, 7'h40, 7'h40, 7'h7f, 1'b1};
    vecs[4] = '{48, 27, 7'h00, 7'h19, 7'h78, 7'h24, 1'b0};
    vecs[5] = '{60, 10, 7'h40, 7'h02, 7'h40, 7'h79, 1'b0};
    k = 0;
    checks = 0;
    passed = 0;
    bus.seconds = 6'd0;
    bus.minutes = 6'd0;
    bus.blank = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check("reset_async", 4'hf, 7'h7f, 1'b1);
    repeat (3) @(posedge clock);
    #1 check("reset_hold", 4'hf, 7'h7f, 1'b1);
    reset = 1'b0;
    k = 0;
    tick();
    tick();
    check("rel_d0", 4'b1110, 7'h40, 1'b1);

    for (int i = 0; i < 6; i++) begin
      bus.seconds = 6'(vecs[i].sec);
      bus.minutes = 6'(vecs[i].min);
      push_vec(i, vecs[i]);
      to_frame();
      observe_frame();
    end

    // Snapshot hold: change input mid-frame, update only after wrap
    bus.seconds = 6'd10;
    bus.minutes = 6'd0;
    to_frame();
    base = k;
    tick_to(base + 9);
    check("hold_d1", 4'b1101, 7'h79, 1'b1);
    bus.seconds = 6'd11;
    tick_to(base + 20);
    check("hold_d2", 4'b1011, 7'h40, 1'b0);
    tick_to(base + 28);
    check("hold_d3", 4'hf, 7'h7f, 1'b1);
    tick_to(base + 33);
    while (k < base + 40) begin
      check($sformatf("hold_d0_k%0d", k - base), 4'b1110, 7'h40, 1'b1);
      tick();
    end
    check("upd_d0", 4'b1110, 7'h79, 1'b1);

    // Blank does not stall the scan
    bus.seconds = 6'd37;
    bus.minutes = 6'd12;
    to_frame();
    base = k;
    tick_to(base + 5);
    bus.blank = 1'b1;
    repeat (20) begin
      tick();
      check($sformatf("blank_k%0d", k - base), 4'hf, 7'h7f, 1'b1);
    end
    bus.blank = 1'b0;
    tick();
    check("blank_resume_d3", 4'b0111, 7'h79, 1'b1);
    tick_to(base + 34);
    check("blank_next_d0", 4'b1110, 7'h78, 1'b1);

    // Reset mid-conversion, then again at d=2
    bus.seconds = 6'd48;
    bus.minutes = 6'd27;
    do tick(); while (k % FRAME != 0);
    repeat (3) tick();
    reset = 1'b1;
    #1 check("rst_conv", 4'hf, 7'h7f, 1'b1);
    bus.seconds = 6'd9;
    bus.minutes = 6'd5;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    k = 0;
    tick_to(20);
    check("pre_rst_d2", 4'b1011, 7'h12, 1'b0);
    reset = 1'b1;
    #1 check("rst_d2", 4'hf, 7'h7f, 1'b1);
    bus.seconds = 6'd45;
    bus.minutes = 6'd31;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    k = 0;
    tick();
    check("rst_restart_d0", 4'b1110, 7'h40, 1'b1);
    tick_to(8);
    check("rst_no_early", 4'b1110, 7'h40, 1'b1);
    push(4'b1101, 7'h19, 1'b1, "rst_d1");
    push(4'b1011, 7'h79, 1'b0, "rst_d2v");
    push(4'b0111, 7'h30, 1'b1, "rst_d3");
    push(4'b1110, 7'h12, 1'b1, "rst_d0");
    tick_to(12);
    pop_check();
    tick_to(20);
    pop_check();
    tick_to(28);
    pop_check();
    tick_to(36);
    pop_check();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
